// File: rtl/mmio_uart_tx.sv
// MMIO-mapped UART transmitter: byte FIFO behind a TXDATA/STATUS register window feeding an 8N1 shifter.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        sel_i,
    input  logic [3:0]  addr_i,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        tx_o,
    output logic        irq_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0] ADDR_TXDATA = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t      state, state_nxt;
    logic [15:0] baud, baud_nxt;
    logic [2:0]  bit_idx, bit_nxt;
    logic [7:0]  data, data_nxt;
    logic        tx_nxt;
    logic        pop;

    // FIFO storage; the extra pointer bit separates full from empty
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, count;
    logic        full, empty;

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    logic wr_req, push, ovf_set, rd_status, overflow;

    assign wr_req    = sel_i && we_i && (addr_i == ADDR_TXDATA);
    // A pop in the same cycle frees the slot, so a write to a full FIFO still lands
    assign push      = wr_req && (!full || pop);
    assign ovf_set   = wr_req && full && !pop;
    assign rd_status = sel_i && !we_i && (addr_i == ADDR_STATUS);

    logic [6:0]  count_ext;
    logic [3:0]  count_sat;
    logic        busy;
    logic [31:0] status;

    assign count_ext = 7'(count);
    assign count_sat = (count_ext > 7'd15) ? 4'hF : count_ext[3:0];
    assign busy      = (state != IDLE);
    assign status    = {24'h0, count_sat, overflow, busy, empty, full};
    assign irq_o     = empty && !busy;

    logic unused_wdata;
    assign unused_wdata = ^wdata_i[31:8];

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud;
        bit_nxt   = bit_idx;
        data_nxt  = data;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                baud_nxt = '0;
                if (!empty) begin
                    pop       = 1'b1;
                    data_nxt  = mem[rd_ptr[AW-1:0]];
                    state_nxt = START;
                    baud_nxt  = BAUD_RELOAD;
                end
            end
            START: begin
                if (baud == '0) begin
                    state_nxt = DATA;
                    baud_nxt  = BAUD_RELOAD;
                    bit_nxt   = 3'd0;
                end else begin
                    baud_nxt = baud - 16'd1;
                end
            end
            DATA: begin
                if (baud == '0) begin
                    baud_nxt = BAUD_RELOAD;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    baud_nxt = baud - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud == '0) begin
                    state_nxt = STOP;
                    baud_nxt  = BAUD_RELOAD;
                end else begin
                    baud_nxt = baud - 16'd1;
                end
            end
`endif
            STOP: begin
                if (baud == '0) begin
                    // Chain straight into the next start bit when more data is queued
                    if (!empty) begin
                        pop       = 1'b1;
                        data_nxt  = mem[rd_ptr[AW-1:0]];
                        state_nxt = START;
                        baud_nxt  = BAUD_RELOAD;
                    end else begin
                        state_nxt = IDLE;
                        baud_nxt  = '0;
                    end
                end else begin
                    baud_nxt = baud - 16'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                baud_nxt  = '0;
            end
        endcase

        // Line level for the state being entered, so tx_o lines up with the state register
        tx_nxt = 1'b1;
        case (state_nxt)
            IDLE:    tx_nxt = 1'b1;
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = data_nxt[bit_nxt];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_nxt = ^data_nxt;
`endif
            STOP:    tx_nxt = 1'b1;
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rstn_i && push) begin
            mem[wr_ptr[AW-1:0]] <= wdata_i[7:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            baud     <= '0;
            bit_idx  <= '0;
            data     <= '0;
            tx_o     <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            rdata_o  <= '0;
        end else begin
            baud    <= baud_nxt;
            bit_idx <= bit_nxt;
            data    <= data_nxt;
            tx_o    <= tx_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // A new overflow wins over the clear from a simultaneous STATUS read
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (rd_status) begin
                overflow <= 1'b0;
            end
            if (sel_i) begin
                rdata_o <= (addr_i == ADDR_STATUS) ? status : 32'h0;
            end
        end
    end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per UART bit; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 8, transmit FIFO entries; power of two, 2..64.
REQ-003 clk_i  in  1  the block's only clock; all state updates on its rising edge.
REQ-004 rstn_i  in  1  synchronous, active-low reset.
REQ-005 sel_i  in  1  high when the core's decoded address falls in this block's MMIO window.
REQ-006 addr_i  in  4  byte offset within the window: 0x0 = TXDATA, 0x4 = STATUS.
REQ-007 we_i  in  1  store strobe from the core, sampled with sel_i.
REQ-008 wdata_i  in  32  store data; only bits [7:0] are used.
REQ-009 rdata_o  out  32  registered read data.
REQ-010 tx_o  out  1  UART serial line; idles high.
REQ-011 irq_o  out  1  high while the FIFO is empty and the shifter is idle.

Function
REQ-012 A write with sel_i=1, we_i=1, addr_i=0x0 and the FIFO not full shall push wdata_i[7:0] into the FIFO on that edge.
REQ-013 A TXDATA write with the FIFO full shall be dropped and shall set the sticky overflow flag.
REQ-014 Writes to STATUS or to undefined offsets shall have no effect.
REQ-015 rdata_o shall update one cycle after any cycle with sel_i=1, giving that cycle's addr_i contents; rdata_o shall read 0 for TXDATA and for undefined offsets.
REQ-016 STATUS layout: bit0 fifo_full, bit1 fifo_empty, bit2 tx_busy, bit3 overflow, bits[7:4] fifo count saturated at 15, all other bits 0.
REQ-017 A STATUS read shall clear overflow on the edge it is sampled; an overflow set in the same cycle shall take priority and remain set.
REQ-018 The transmit FSM states shall be IDLE, START, DATA, PARITY (macro-dependent), and STOP.
REQ-019 In IDLE with the FIFO non-empty, the FSM shall pop the head entry into the shift register and enter START on the next edge.
REQ-020 Each non-IDLE state shall hold for exactly CLKS_PER_BIT cycles, timed by a baud counter reloaded on every state entry.
REQ-021 Bit values: START drives tx_o=0; DATA sends 8 bits LSB first; STOP drives tx_o=1.
REQ-022 After STOP, the FSM shall go directly to START when the FIFO is non-empty, giving back-to-back frames with no idle gap; otherwise it shall go to IDLE.
REQ-023 A push and a pop in the same cycle shall leave the count unchanged and lose no data, including when the FIFO is full (the pop frees the slot) and when it is empty (the push is not visible to that pop).
REQ-024 FIFO pointers shall wrap modulo FIFO_DEPTH; full and empty shall be distinguished by an extra pointer bit.
REQ-025 tx_busy shall be 1 in every state except IDLE.
REQ-026 tx_o shall be registered, with no combinational path from any input.

Reset
REQ-027 While rstn_i=0 at a rising edge, the block shall set tx_o=1, rdata_o=0, FSM=IDLE, FIFO empty, overflow=0 and baud counter=0.
REQ-028 irq_o shall be 1 after reset.
REQ-029 A reset during a frame shall abort the frame and drive tx_o high from the next edge; FIFO contents shall be discarded.

Configuration
REQ-030 When macro UART_TX_PARITY_EN is defined, the frame shall include a PARITY state between DATA and STOP carrying even parity (XOR of the 8 data bits), making the frame 11 bits.
REQ-031 When UART_TX_PARITY_EN is undefined, the PARITY state shall not exist and the frame shall be 10 bits.

Verification
REQ-032 The bench shall use CLKS_PER_BIT=4 for all scenarios.
REQ-033 Write 0x55 to TXDATA -> tx_o = 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles; frame is 40 cycles (44 cycles with parity enabled, parity bit 0).
REQ-034 Write 0xA5 then 0x3C on consecutive cycles -> two back-to-back frames with no high gap between the first STOP and the second START.
REQ-035 Fill the FIFO with 9 writes while the first frame is transmitting -> the 10th write is dropped, STATUS bit3=1 and bit0=1; reading STATUS then reading it again returns bit3=0.
REQ-036 Read STATUS at reset -> rdata_o=0x00000002 one cycle later and irq_o=1; after one write and the full frame, irq_o returns to 1.
REQ-037 Assert rstn_i low for 1 cycle mid-DATA -> tx_o=1 on the next edge, STATUS=0x2, and no further frames are sent.
